// File: rtl/bus_xfer_ctrl.sv
// Bus transfer controller: queues register moves and sequences per-register LDBUS/WR strobes.
// Define BUS_XFER_COUNT_EN to add the 16-bit xfer_count output.
module bus_xfer_ctrl #(
  parameter int NREG   = 8,
  parameter int SELW   = 3,
  parameter int QDEPTH = 4
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            req_valid,
  input  logic [SELW-1:0] req_src,
  input  logic [SELW-1:0] req_dst,
  output logic            req_ready,
  output logic [NREG-1:0] ldbus,
  output logic [NREG-1:0] wr,
  output logic            busy,
  output logic            done,
  output logic            err
`ifdef BUS_XFER_COUNT_EN
  ,
  output logic [15:0]     xfer_count
`endif
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]   QDEPTH_C = CW'(QDEPTH);
  localparam logic [SELW:0]   NREG_C   = (SELW+1)'(NREG);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WRITE = 2'd2
  } state_t;

  function automatic logic legal(input logic [SELW-1:0] s, input logic [SELW-1:0] d);
    return (s != d) && ({1'b0, s} < NREG_C) && ({1'b0, d} < NREG_C);
  endfunction

  function automatic logic [NREG-1:0] onehot(input logic [SELW-1:0] idx);
    return {{(NREG-1){1'b0}}, 1'b1} << idx;
  endfunction

  logic [SELW-1:0] src_mem [QDEPTH];
  logic [SELW-1:0] dst_mem [QDEPTH];

  state_t          state_q,     state_d;
  logic [PW-1:0]   wr_ptr_q,    wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q,    rd_ptr_d;
  logic [CW-1:0]   count_q,     count_d;
  logic [SELW-1:0] cur_src_q,   cur_src_d;
  logic [SELW-1:0] cur_dst_q,   cur_dst_d;
  logic            req_ready_q, req_ready_d;
  logic [NREG-1:0] ldbus_q,     ldbus_d;
  logic [NREG-1:0] wr_q,        wr_d;
  logic            busy_q,      busy_d;
  logic            done_q,      done_d;
  logic            err_q,       err_d;
`ifdef BUS_XFER_COUNT_EN
  logic [15:0]     xfer_count_q, xfer_count_d;
`endif

  logic            push_s;
  logic            pop_s;
  logic [SELW-1:0] head_src_s;
  logic [SELW-1:0] head_dst_s;

  assign push_s     = req_valid & req_ready_q;
  assign head_src_s = src_mem[rd_ptr_q];
  assign head_dst_s = dst_mem[rd_ptr_q];

  // Next-state, queue bookkeeping and next registered outputs
  always_comb begin
    state_d   = state_q;
    cur_src_d = cur_src_q;
    cur_dst_d = cur_dst_q;
    pop_s     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE, WRITE: begin
        if (count_q != {CW{1'b0}}) begin
          pop_s = 1'b1;
          if (legal(head_src_s, head_dst_s)) begin
            state_d   = DRIVE;
            cur_src_d = head_src_s;
            cur_dst_d = head_dst_s;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DRIVE:   state_d = WRITE;
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_s) - CW'(pop_s);

    // Source keeps driving through WRITE so the bus never floats mid-transfer
    ldbus_d     = (state_d != IDLE)  ? onehot(cur_src_d) : {NREG{1'b0}};
    wr_d        = (state_d == WRITE) ? onehot(cur_dst_d) : {NREG{1'b0}};
    done_d      = (state_d == WRITE);
    busy_d      = (state_d != IDLE) || (count_d != {CW{1'b0}});
    req_ready_d = (count_d < QDEPTH_C);
`ifdef BUS_XFER_COUNT_EN
    xfer_count_d = (state_q == WRITE) ? xfer_count_q + 16'd1 : xfer_count_q;
`endif
  end

  // Request queue storage; pointers alone define validity so no reset needed
  always_ff @(posedge clk) begin
    if (push_s) begin
      src_mem[wr_ptr_q] <= req_src;
      dst_mem[wr_ptr_q] <= req_dst;
    end
  end

  // State and registered outputs, synchronous reset has priority
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= IDLE;
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      cur_src_q   <= {SELW{1'b0}};
      cur_dst_q   <= {SELW{1'b0}};
      req_ready_q <= 1'b1;
      ldbus_q     <= {NREG{1'b0}};
      wr_q        <= {NREG{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef BUS_XFER_COUNT_EN
      xfer_count_q <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cur_src_q   <= cur_src_d;
      cur_dst_q   <= cur_dst_d;
      req_ready_q <= req_ready_d;
      ldbus_q     <= ldbus_d;
      wr_q        <= wr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef BUS_XFER_COUNT_EN
      xfer_count_q <= xfer_count_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign ldbus     = ldbus_q;
  assign wr        = wr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
`ifdef BUS_XFER_COUNT_EN
  assign xfer_count = xfer_count_q;
`endif

endmodule
